// File: rtl/fo_filter_bank.sv
// Time-multiplexed first-order filter bank: one shared datapath, per-channel x/y history.
// Define FOF_SAT_EN to clamp out-of-range results and drive sat_flag; otherwise results wrap.
module fo_filter_bank #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int SHIFT    = 2,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [CH_W-1:0]  in_ch,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       mode,
    input  logic             clear,
    output logic             out_valid,
    output logic [CH_W-1:0]  out_ch,
    output logic [WIDTH-1:0] out_data,
    output logic             sat_flag
);

    localparam int EW = WIDTH + 2;
    localparam logic [31:0] CHANNELS_U = 32'(CHANNELS);

    logic [CHANNELS-1:0][WIDTH-1:0] x_prev_all;
    logic [CHANNELS-1:0][WIDTH-1:0] y_prev_all;

    logic                 ch_ok;
    logic                 accept;
    logic [WIDTH-1:0]     x_hist;
    logic [WIDTH-1:0]     y_hist;
    logic signed [EW-1:0] xe;
    logic signed [EW-1:0] xp;
    logic signed [EW-1:0] yp;
    logic signed [EW-1:0] diff;
    logic signed [EW-1:0] exact;
    logic [WIDTH-1:0]     res_d;

    logic                 out_valid_q;
    logic [CH_W-1:0]      out_ch_q;
    logic [WIDTH-1:0]     out_data_q;

    assign ch_ok  = ({{(32-CH_W){1'b0}}, in_ch} < CHANNELS_U);
    assign accept = in_valid && ch_ok;

    // A simultaneous clear means the sample sees zero history in every channel.
    always_comb begin
        x_hist = '0;
        y_hist = '0;
        if (ch_ok && !clear) begin
            x_hist = x_prev_all[in_ch];
            y_hist = y_prev_all[in_ch];
        end
    end

    always_comb begin
        xe    = {{2{in_data[WIDTH-1]}}, in_data};
        xp    = {{2{x_hist[WIDTH-1]}}, x_hist};
        yp    = {{2{y_hist[WIDTH-1]}}, y_hist};
        diff  = xe - yp;
        exact = '0;
        case (mode)
            2'd0:    exact = xe + yp;
            2'd1:    exact = xe - xp;
            2'd2:    exact = yp + (diff >>> SHIFT);
            default: exact = (xe + xp) >>> 1;
        endcase
    end

`ifdef FOF_SAT_EN
    localparam logic signed [EW-1:0] MAX_V = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] MIN_V = {3'b111, {(WIDTH-1){1'b0}}};

    logic sat_d;
    logic sat_q;

    always_comb begin
        sat_d = 1'b0;
        res_d = exact[WIDTH-1:0];
        if (exact > MAX_V) begin
            sat_d = 1'b1;
            res_d = MAX_V[WIDTH-1:0];
        end else if (exact < MIN_V) begin
            sat_d = 1'b1;
            res_d = MIN_V[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sat_q <= 1'b0;
        end else if (accept) begin
            sat_q <= sat_d;
        end
    end

    assign sat_flag = sat_q;
`else
    logic unused_hi;

    // Two's complement wrap: the guard bits are simply dropped.
    assign res_d     = exact[WIDTH-1:0];
    assign unused_hi = ^exact[EW-1:WIDTH];
    assign sat_flag  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= accept;
            if (accept) begin
                out_ch_q   <= in_ch;
                out_data_q <= res_d;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_hist
            logic [WIDTH-1:0] x_q;
            logic [WIDTH-1:0] y_q;

            // An accepted sample on this channel wins over a concurrent clear.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    x_q <= '0;
                    y_q <= '0;
                end else if (accept && (in_ch == CH_W'(gi))) begin
                    x_q <= in_data;
                    y_q <= res_d;
                end else if (clear) begin
                    x_q <= '0;
                    y_q <= '0;
                end
            end

            assign x_prev_all[gi] = x_q;
            assign y_prev_all[gi] = y_q;
        end
    endgenerate

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_fo_filter_bank.sv
// Scoreboard bench for fo_filter_bank: directed cases plus randomized traffic against a behavioural model.
module tb_fo_filter_bank;

    localparam int WIDTH = 16;
    localparam int SHIFT = 2;
    localparam int NCH   = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [1:0]  in_ch;
    logic [15:0] in_data;
    logic [1:0]  mode;
    logic        clear;
    logic        out_valid;
    logic [1:0]  out_ch;
    logic [15:0] out_data;
    logic        sat_flag;

    logic        in_valid5;
    logic [2:0]  in_ch5;
    logic        out_valid5;
    logic [2:0]  out_ch5;
    logic [15:0] out_data5;
    logic        sat_flag5;

    always #5 clk = ~clk;

    fo_filter_bank #(.WIDTH(WIDTH), .CHANNELS(NCH), .SHIFT(SHIFT)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ch(in_ch),
        .in_data(in_data), .mode(mode), .clear(clear), .out_valid(out_valid),
        .out_ch(out_ch), .out_data(out_data), .sat_flag(sat_flag)
    );

    // Five-channel instance so that channel indices beyond CHANNELS are reachable.
    fo_filter_bank #(.WIDTH(WIDTH), .CHANNELS(5), .SHIFT(SHIFT)) dut5 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid5), .in_ch(in_ch5),
        .in_data(in_data), .mode(mode), .clear(clear), .out_valid(out_valid5),
        .out_ch(out_ch5), .out_data(out_data5), .sat_flag(sat_flag5)
    );

    typedef struct {
        int ch;
        int data;
        int sat;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_exp = 0;
    bit   hold_en = 1'b0;
    int   mx[NCH];
    int   my[NCH];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, act, req);
        end
    endtask

    function automatic void model_zero();
        for (int i = 0; i < NCH; i++) begin
            mx[i] = 0;
            my[i] = 0;
        end
    endfunction

    // y[n] from the filter equations on plain integers, then range-reduced.
    function automatic void model_calc(input int ch, input int x, input int md,
                                       output int r, output int s);
        int e;
        int xp;
        int yp;
        xp = mx[ch];
        yp = my[ch];
        case (md)
            0:       e = x + yp;
            1:       e = x - xp;
            2:       e = yp + ((x - yp) >>> SHIFT);
            default: e = (x + xp) >>> 1;
        endcase
        s = 0;
`ifdef FOF_SAT_EN
        if (e > 32767) begin
            r = 32767;
            s = 1;
        end else if (e < -32768) begin
            r = -32768;
            s = 1;
        end else begin
            r = e;
        end
`else
        r = int'($signed(e[15:0]));
`endif
    endfunction

    task automatic send(input int ch, input int x, input int md, input bit clr,
                        input bit use_req, input int req);
        int   r;
        int   s;
        exp_t e;
        in_valid = 1'b1;
        in_ch    = 2'(ch);
        in_data  = 16'(x);
        mode     = 2'(md);
        clear    = clr;
        if (clr) model_zero();
        model_calc(ch, x, md, r, s);
        e.ch   = ch;
        e.data = use_req ? req : r;
        e.sat  = s;
        e.cyc  = cyc + 1;
        q.push_back(e);
        mx[ch] = x;
        my[ch] = r;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic idle(input int n, input bit clr);
        in_valid = 1'b0;
        clear    = clr;
        if (clr) model_zero();
        repeat (n) @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic send5(input int ch, input int x, input bit req_v, input int req_d);
        in_valid5 = 1'b1;
        in_ch5    = 3'(ch);
        in_data   = 16'(x);
        mode      = 2'd0;
        @(posedge clk);
        #1;
        in_valid5 = 1'b0;
        chk("ch5_out_valid", int'(out_valid5), int'(req_v));
        if (req_v) chk("ch5_out_data", int'($signed(out_data5)), req_d);
    endtask

    task automatic do_reset();
        hold_en = 1'b0;
        in_valid = 1'b0;
        in_valid5 = 1'b0;
        clear = 1'b0;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_data", int'(out_data), 0);
        chk("reset_out_ch", int'(out_ch), 0);
        chk("reset_sat_flag", int'(sat_flag), 0);
        reset_n = 1'b1;
        model_zero();
        last_exp = 0;
        hold_en = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (out_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got ch=%0d data=%0d expected no output",
                         out_ch, $signed(out_data));
            end else begin
                e = q.pop_front();
                if (int'(out_ch) != e.ch || int'($signed(out_data)) != e.data ||
                    int'(sat_flag) != e.sat || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL result got ch=%0d data=%0d sat=%0d cyc=%0d expected ch=%0d data=%0d sat=%0d cyc=%0d",
                             out_ch, $signed(out_data), sat_flag, cyc, e.ch, e.data, e.sat, e.cyc);
                end
                last_exp = e.data;
            end
        end else if (hold_en) begin
            checks++;
            if (int'($signed(out_data)) != last_exp) begin
                errors++;
                $display("FAIL hold got data=%0d expected %0d", $signed(out_data), last_exp);
            end
        end
    end

    initial begin
        in_valid  = 1'b0;
        in_ch     = '0;
        in_data   = '0;
        mode      = '0;
        clear     = 1'b0;
        in_valid5 = 1'b0;
        in_ch5    = '0;
        reset_n   = 1'b0;
        model_zero();
        @(posedge clk);
        #1;
        do_reset();

        // out-of-range channels on the five-channel instance
        send5(5, 9, 1'b0, 0);
        send5(7, 9, 1'b0, 0);
        send5(4, 9, 1'b1, 9);
        send5(4, 9, 1'b1, 18);
        send5(5, 1, 1'b0, 0);
        send5(4, 1, 1'b1, 19);

        send(0, 100, 1, 1'b0, 1'b1, 100);
        send(0, 40, 1, 1'b0, 1'b1, -60);
        send(1, 30000, 0, 1'b0, 1'b1, 30000);
`ifdef FOF_SAT_EN
        send(1, 30000, 0, 1'b0, 1'b1, 32767);
`else
        send(1, 30000, 0, 1'b0, 1'b1, -5536);
`endif
        send(2, 1000, 2, 1'b0, 1'b1, 250);
        send(2, 1000, 2, 1'b0, 1'b1, 437);
        send(2, 1000, 2, 1'b0, 1'b1, 577);
        send(2, -3, 3, 1'b0, 1'b1, 498);
        idle(1, 1'b1);
        idle(1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            send(0, 10, 0, 1'b0, 1'b1, 10 * i);
            send(3, 7, 0, 1'b0, 1'b1, 7 * i);
        end
        send(1, 200, 0, 1'b0, 1'b1, 200);
        send(1, 5, 0, 1'b1, 1'b1, 5);
        send(1, 5, 0, 1'b0, 1'b1, 10);
        idle(2, 1'b0);
        do_reset();
        send(2, 3, 0, 1'b0, 1'b1, 3);

        for (int n = 0; n < 400; n++) begin
            if (($urandom % 4) != 0) begin
                send(int'($urandom_range(NCH - 1)), int'($urandom_range(65535)) - 32768,
                     int'($urandom_range(3)), (($urandom % 16) == 0), 1'b0, 0);
            end else begin
                idle(1, (($urandom % 8) == 0));
            end
        end

        idle(3, 1'b0);
        chk("scoreboard_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
